addsub_arbiter: RTL
===================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 16 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0  in  1  requester 0 operation request, held until gnt0.
REQ-005 in1_0, in2_0  in  16 each  requester 0 operands, stable while req0=1.
REQ-006 sub0  in  1  requester 0 op select: 0 = in1_0+in2_0, 1 = in1_0-in2_0.
REQ-007 req1, in1_1, in2_1, sub1  in  1/16/16/1  requester 1, same meaning.
REQ-008 gnt0, gnt1  out  1 each  registered one-cycle pulse; operands captured.
REQ-009 done0, done1  out  1 each  registered one-cycle pulse; result valid on s/ovf.
REQ-010 s  out  16  registered result of the last completed operation.
REQ-011 ovf  out  1  registered two's-complement signed overflow of the last completed operation.

Function
REQ-012 SHALL contain exactly one addsub16bit instance; both requesters share it; no other adder in the datapath.
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 IDLE, no req at edge: stay IDLE; gnt*/done* = 0.
REQ-015 IDLE, >=1 req at edge: select winner, load op_a/op_b/op_sub registers from winner's in1/in2/sub, set winner's gnt=1 for the following cycle, go BUSY.
REQ-016 Arbitration: single requester always wins; both requesting -> requester named by priority pointer prio wins.
REQ-017 prio SHALL be set to the non-winning requester on every grant (round-robin); unchanged when no grant.
REQ-018 BUSY: adder driven from op registers; at next edge load s <= adder sum, ovf <= overflow, set winner's done=1 for the following cycle, go IDLE.
REQ-019 Requests sampled in BUSY SHALL be ignored; a request still high in the next IDLE is arbitrated normally.
REQ-020 Latency: req sampled at edge N -> gnt high in cycle N..N+1 -> done high in cycle N+1..N+2; max throughput one operation per 2 cycles.
REQ-021 ovf = (op_a[15] == (op_b[15]^op_sub)) && (sum[15] != op_a[15]); carry-out of bit 15 SHALL be discarded.
REQ-022 Subtraction SHALL be two's complement (invert in2, carry-in 1), wrapping modulo 2^16.
REQ-023 s and ovf SHALL hold their value between done pulses.
REQ-024 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle; gnt and done never high in the same cycle.
REQ-025 Requester deasserting req before gnt: request withdrawn; no gnt/done for it.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, prio=0, gnt0=gnt1=done0=done1=0, s=0x0000, ovf=0, op registers 0.
REQ-027 rst asserted while BUSY SHALL abort the operation; no done pulse issued for it after release.
REQ-028 First edge after rst release SHALL arbitrate normally from IDLE.

Verification
REQ-029 Reset: assert rst mid-cycle -> all outputs 0 without waiting for clk edge.
REQ-030 req0 alone, in1_0=0x0005, in2_0=0x0003, sub0=0 -> gnt0 one cycle later, done0 next cycle, s=0x0008, ovf=0.
REQ-031 req1 alone, in1_1=0x0003, in2_1=0x0005, sub1=1 -> gnt1, then done1, s=0xFFFE, ovf=0.
REQ-032 req0 and req1 held continuously after reset -> grant order 0,1,0,1, one gnt per 2 cycles, each done on the matching requester.
REQ-033 Overflow: 0x7FFF+0x0001 -> s=0x8000, ovf=1; 0x8000-0x0001 -> s=0x7FFF, ovf=1; 0xFFFF+0x0001 -> s=0x0000, ovf=0.
REQ-034 rst pulsed in BUSY after gnt0 -> no done0; s=0x0000; then simultaneous req0/req1 -> gnt0 first (prio reset to 0).

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one 16-bit add/subtract unit.
// Round-robin on contention; a grant is followed one cycle later by done and result.

module addsub16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovf
);

  logic [15:0] b_eff;

  // Subtract as a + ~b + 1; the carry out of bit 15 is dropped by the 16-bit sum.
  always_comb begin
    b_eff = b ^ {16{sub}};
    sum   = a + b_eff + {15'd0, sub};
    ovf   = (a[15] == (b[15] ^ sub)) && (sum[15] != a[15]);
  end

endmodule

// state | meaning
// IDLE  | waiting for a request; arbitrates and captures operands on a request
// BUSY  | operands held in op registers; result and done registered at next edge
module addsub_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] in1_0,
  input  logic [15:0] in2_0,
  input  logic        sub0,
  input  logic        req1,
  input  logic [15:0] in1_1,
  input  logic [15:0] in2_1,
  input  logic        sub1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] s,
  output logic        ovf
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        owner;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_sub;
  logic        any_req;
  logic        winner;
  logic        grant;
  logic        gnt0_nxt;
  logic        gnt1_nxt;
  logic        done0_nxt;
  logic        done1_nxt;
  logic [15:0] add_sum;
  logic        add_ovf;

  addsub16bit u_addsub (
    .a   (op_a),
    .b   (op_b),
    .sub (op_sub),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    any_req   = req0 | req1;
    winner    = (req0 && req1) ? prio : req1;
    grant     = (state == IDLE) && any_req;
    gnt0_nxt  = grant && !winner;
    gnt1_nxt  = grant && winner;
    done0_nxt = (state == BUSY) && !owner;
    done1_nxt = (state == BUSY) && owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio   <= 1'b0;
      owner  <= 1'b0;
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      op_sub <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      s      <= 16'h0000;
      ovf    <= 1'b0;
    end else begin
      gnt0  <= gnt0_nxt;
      gnt1  <= gnt1_nxt;
      done0 <= done0_nxt;
      done1 <= done1_nxt;
      if (grant) begin
        owner  <= winner;
        prio   <= ~winner;
        op_a   <= winner ? in1_1 : in1_0;
        op_b   <= winner ? in2_1 : in2_0;
        op_sub <= winner ? sub1 : sub0;
      end
      if (state == BUSY) begin
        s   <= add_sum;
        ovf <= add_ovf;
      end
    end
  end

endmodule
